// File: rtl/store_buffer.sv
// Circular store buffer between the core and data memory.
// The youngest buffered store to a matching address is forwarded to loads.
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 17
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       we,
    input  logic [WIDTH-1:0]           address,
    input  logic [WIDTH-1:0]           wd,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    input  logic [WIDTH-1:0]           fwd_address,
    output logic                       fwd_hit,
    output logic [WIDTH-1:0]           fwd_data,
    output logic                       mem_we,
    output logic [WIDTH-1:0]           mem_address,
    output logic [WIDTH-1:0]           mem_wd,
    input  logic                       mem_ready
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] addr_mem [DEPTH];
    logic [WIDTH-1:0] data_mem [DEPTH];

    logic [PTR_W-1:0] head_reg, head_next;
    logic [PTR_W-1:0] tail_reg, tail_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic             overflow_reg, overflow_next;
    logic             enq, deq;
    logic [DEPTH-1:0] match;
    logic [PTR_W-1:0] fwd_idx;

    assign full     = (count_reg == CNT_W'(DEPTH));
    assign empty    = (count_reg == '0);
    assign count    = count_reg;
    assign overflow = overflow_reg;
    assign mem_we   = !empty;

    // Acceptance looks only at the registered count, so a full buffer
    // rejects a store even when the head drains in the same cycle.
    assign enq = we && !full;
    assign deq = mem_we && mem_ready;

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_comb begin
        head_next     = head_reg + PTR_W'(deq);
        tail_next     = tail_reg + PTR_W'(enq);
        overflow_next = overflow_reg | (we & full);
        count_next    = count_reg;
        case ({enq, deq})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_reg     <= '0;
            tail_reg     <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            head_reg     <= head_next;
            tail_reg     <= tail_next;
            count_reg    <= count_next;
            overflow_reg <= overflow_next;
        end
    end

    // Entry storage is never cleared; validity comes from head/count alone.
    always_ff @(posedge clk) begin
        if (!reset && enq) begin
            addr_mem[tail_reg] <= address;
            data_mem[tail_reg] <= wd;
        end
    end

    assign mem_address = empty ? '0 : addr_mem[head_reg];
    assign mem_wd      = empty ? '0 : data_mem[head_reg];

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
            assign match[gi] = (addr_mem[gi] == fwd_address);
        end
    endgenerate

    // Walk entries oldest to youngest so the last valid match wins.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        fwd_idx  = head_reg;
        for (int k = 0; k < DEPTH; k++) begin
            fwd_idx = head_reg + PTR_W'(k);
            if ((CNT_W'(k) < count_reg) && match[fwd_idx]) begin
                fwd_hit  = 1'b1;
                fwd_data = data_mem[fwd_idx];
            end
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: reset, latency, overflow, wrap, forwarding.
module tb_store_buffer;

    localparam int DEPTH = 4;
    localparam int WIDTH = 17;

    logic             clk = 1'b0;
    logic             reset;
    logic             we;
    logic [WIDTH-1:0] address;
    logic [WIDTH-1:0] wd;
    logic             full;
    logic             empty;
    logic [2:0]       count;
    logic             overflow;
    logic [WIDTH-1:0] fwd_address;
    logic             fwd_hit;
    logic [WIDTH-1:0] fwd_data;
    logic             mem_we;
    logic [WIDTH-1:0] mem_address;
    logic [WIDTH-1:0] mem_wd;
    logic             mem_ready;

    int n_checks = 0;
    int n_errors = 0;

    logic [WIDTH-1:0] log_addr [$];
    logic [WIDTH-1:0] log_data [$];

    store_buffer #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .we          (we),
        .address     (address),
        .wd          (wd),
        .full        (full),
        .empty       (empty),
        .count       (count),
        .overflow    (overflow),
        .fwd_address (fwd_address),
        .fwd_hit     (fwd_hit),
        .fwd_data    (fwd_data),
        .mem_we      (mem_we),
        .mem_address (mem_address),
        .mem_wd      (mem_wd),
        .mem_ready   (mem_ready)
    );

    always #5 clk = ~clk;

    // Record what memory actually accepts; inputs are stable at the falling edge.
    always @(negedge clk) begin
        if (!reset && mem_we && mem_ready) begin
            log_addr.push_back(mem_address);
            log_data.push_back(mem_wd);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        log_addr.delete();
        log_data.delete();
    endtask

    task automatic do_store(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] d);
        we      = 1'b1;
        address = a;
        wd      = d;
        tick();
        we = 1'b0;
        $display("store addr=%05h data=%05h count=%0d full=%0b overflow=%0b",
                 a, d, count, full, overflow);
    endtask

    task automatic chk_log(input string tag, input int idx,
                           input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] d);
        if (idx < log_addr.size()) begin
            chk({tag, "_addr"}, 32'(log_addr[idx]), 32'(a));
            chk({tag, "_data"}, 32'(log_data[idx]), 32'(d));
        end else begin
            chk({tag, "_missing"}, 32'(log_addr.size()), 32'(idx + 1));
        end
    endtask

    initial begin
        reset = 1'b1; we = 1'b0; address = '0; wd = '0;
        fwd_address = '0; mem_ready = 1'b0;
        tick();
        do_reset();

        // Reset state
        chk("rst_full",     32'(full),        32'd0);
        chk("rst_empty",    32'(empty),       32'd1);
        chk("rst_count",    32'(count),       32'd0);
        chk("rst_overflow", 32'(overflow),    32'd0);
        chk("rst_mem_we",   32'(mem_we),      32'd0);
        chk("rst_mem_addr", 32'(mem_address), 32'd0);
        chk("rst_mem_wd",   32'(mem_wd),      32'd0);
        chk("rst_fwd_hit",  32'(fwd_hit),     32'd0);
        chk("rst_fwd_data", 32'(fwd_data),    32'd0);

        // Single store: no same-cycle bypass, visible one cycle later
        we = 1'b1; address = 17'h00054; wd = 17'h00007;
        #1;
        chk("single_no_bypass", 32'(mem_we), 32'd0);
        tick();
        we = 1'b0;
        $display("store addr=00054 data=00007 count=%0d", count);
        chk("single_count",    32'(count),       32'd1);
        chk("single_mem_we",   32'(mem_we),      32'd1);
        chk("single_mem_addr", 32'(mem_address), 32'h54);
        chk("single_mem_wd",   32'(mem_wd),      32'h7);
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        chk("single_empty",  32'(empty),  32'd1);
        chk("single_mem_we2", 32'(mem_we), 32'd0);
        chk("single_log_n",  32'(log_addr.size()), 32'd1);
        chk_log("single_log", 0, 17'h54, 17'h7);

        // Fill and overflow
        do_reset();
        for (int i = 0; i < 4; i++) do_store(17'(16 + i), 17'(256 + i));
        chk("fill_full",  32'(full),  32'd1);
        chk("fill_count", 32'(count), 32'd4);
        chk("fill_ovf0",  32'(overflow), 32'd0);
        do_store(17'h14, 17'h104);
        chk("ovf_count",   32'(count),    32'd4);
        chk("ovf_flag",    32'(overflow), 32'd1);
        chk("ovf_head",    32'(mem_address), 32'h10);
        mem_ready = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        mem_ready = 1'b0;
        chk("drain_empty", 32'(empty),    32'd1);
        chk("drain_ovf",   32'(overflow), 32'd1);
        chk("drain_log_n", 32'(log_addr.size()), 32'd4);
        for (int i = 0; i < 4; i++) chk_log("drain_log", i, 17'(16 + i), 17'(256 + i));

        // Wrap-around with continuous enqueue and dequeue
        do_reset();
        mem_ready = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            do_store(17'(64 + i), 17'(i));
            chk("wrap_count", 32'(count), 32'd1);
        end
        tick();
        mem_ready = 1'b0;
        chk("wrap_empty",  32'(empty),    32'd1);
        chk("wrap_ovf",    32'(overflow), 32'd0);
        chk("wrap_log_n",  32'(log_addr.size()), 32'd10);
        for (int i = 1; i <= 10; i++) chk_log("wrap_log", i - 1, 17'(64 + i), 17'(i));

        // Forwarding: youngest match wins, miss yields zero
        do_reset();
        do_store(17'h20, 17'h0AAAA);
        do_store(17'h20, 17'h0BBBB);
        fwd_address = 17'h20;
        #1;
        chk("fwd_hit",       32'(fwd_hit),  32'd1);
        chk("fwd_youngest",  32'(fwd_data), 32'h0BBBB);
        fwd_address = 17'h21;
        #1;
        chk("fwd_miss_hit",  32'(fwd_hit),  32'd0);
        chk("fwd_miss_data", 32'(fwd_data), 32'd0);
        we = 1'b1; address = 17'h21; wd = 17'h01234;
        #1;
        chk("fwd_same_cycle", 32'(fwd_hit), 32'd0);
        tick();
        we = 1'b0;
        chk("fwd_next_hit",  32'(fwd_hit),  32'd1);
        chk("fwd_next_data", 32'(fwd_data), 32'h01234);
        mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        mem_ready = 1'b0;
        fwd_address = 17'h20;
        #1;
        chk("fwd_stale_hit",  32'(fwd_hit),  32'd0);
        chk("fwd_stale_data", 32'(fwd_data), 32'd0);
        chk("fwd_stale_memwd", 32'(mem_wd), 32'd0);

        // Full with simultaneous dequeue and store
        do_reset();
        for (int i = 0; i < 4; i++) do_store(17'(80 + i), 17'(512 + i));
        mem_ready = 1'b1;
        do_store(17'h30, 17'h0CCCC);
        mem_ready = 1'b0;
        chk("simul_count",   32'(count),       32'd3);
        chk("simul_ovf",     32'(overflow),    32'd1);
        chk("simul_head",    32'(mem_address), 32'h51);
        fwd_address = 17'h30;
        #1;
        chk("simul_rejected", 32'(fwd_hit), 32'd0);

        // Reset mid-operation drops pending entries
        do_reset();
        for (int i = 0; i < 3; i++) do_store(17'(96 + i), 17'(768 + i));
        reset = 1'b1; we = 1'b1; address = 17'h77; wd = 17'h77; mem_ready = 1'b1;
        tick();
        reset = 1'b0; we = 1'b0;
        chk("midrst_count",  32'(count),    32'd0);
        chk("midrst_empty",  32'(empty),    32'd1);
        chk("midrst_ovf",    32'(overflow), 32'd0);
        chk("midrst_mem_we", 32'(mem_we),   32'd0);
        for (int i = 0; i < 3; i++) tick();
        mem_ready = 1'b0;
        chk("midrst_log_n",  32'(log_addr.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
